// File: rtl/sync_fifo_watermark.sv
// sync_fifo_watermark
//   Synchronous FIFO with fill count, programmable almost-full/almost-empty
//   watermarks, synchronous flush, sticky overflow/underflow flags and a
//   selectable standard or first-word-fall-through read port.
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   clr_i          synchronous flush (beats write_i/read_i)
//   write_i        write request, data on wr_data_i
//   read_i         read request (FWFT: pops the displayed word)
//   rd_data_o      read data (registered in standard mode)
//   full_o/empty_o count == DEPTH / count == 0
//   almost_full_o  count >= AF_LEVEL
//   almost_empty_o count <= AE_LEVEL
//   count_o        stored entries
//   overflow_o     sticky: a write was dropped
//   underflow_o    sticky: a read was rejected
module sync_fifo_watermark #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clr_i,
  input  logic                    write_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    read_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic                  w_rd_acc, w_wr_acc;

  // A read frees a slot in the same edge, so a full FIFO still accepts a
  // write alongside an accepted read. Reads only see stored data: no bypass.
  assign w_rd_acc = read_i && !r_empty;
  assign w_wr_acc = write_i && (!r_full || w_rd_acc);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Status flags are derived from the next-state count so they are
  // registered on the same edge as count_o and never lag it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= CW'(AF_LEVEL));
      r_ae    <= (w_count_nxt <= CW'(AE_LEVEL));
      if (write_i && !w_wr_acc) r_ovf <= 1'b1;
      if (read_i && !w_rd_acc)  r_udf <= 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc && !clr_i) r_mem[r_wr_ptr] <= wr_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown as soon as it is stored; zero while empty.
      assign rd_data_o = r_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rd_data;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)      r_rd_data <= '0;
        else if (clr_i)    r_rd_data <= '0;
        else if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
      end
      assign rd_data_o = r_rd_data;
    end
  endgenerate

  assign full_o         = r_full;
  assign empty_o        = r_empty;
  assign almost_full_o  = r_af;
  assign almost_empty_o = r_ae;
  assign count_o        = r_count;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;
endmodule

// File: tb/tb_sync_fifo_watermark.sv
module tb_sync_fifo_watermark;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // standard-read instance
  logic       clr = 0, wr = 0, rd = 0;
  logic [7:0] wd = 0, rdata;
  logic       full, empty, af, ae, ovf, udf;
  logic [3:0] cnt;

  // FWFT instance
  logic       fclr = 0, fwr = 0, frd = 0;
  logic [7:0] fwd = 0, f_rdata;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] f_cnt;

  sync_fifo_watermark #(.DATA_WIDTH(8), .DEPTH(D), .FWFT(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .write_i(wr), .wr_data_i(wd),
    .read_i(rd), .rd_data_o(rdata), .full_o(full), .empty_o(empty),
    .almost_full_o(af), .almost_empty_o(ae), .count_o(cnt),
    .overflow_o(ovf), .underflow_o(udf));

  sync_fifo_watermark #(.DATA_WIDTH(8), .DEPTH(D), .FWFT(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(fclr), .write_i(fwr), .wr_data_i(fwd),
    .read_i(frd), .rd_data_o(f_rdata), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_cnt),
    .overflow_o(f_ovf), .underflow_o(f_udf));

  typedef struct {
    logic       clr, wr, rd;
    logic [7:0] wd;
    int         cnt;
    logic       ovf, udf;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] mq[$];     // scoreboard of stored words
  logic [7:0] m_rd = 0;  // expected rd_data_o (standard mode)
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  function automatic vec_t mk(input logic c, w, r, input logic [7:0] d,
                              input int n, input logic o, u);
    vec_t v;
    v.clr = c; v.wr = w; v.rd = r; v.wd = d; v.cnt = n; v.ovf = o; v.udf = u;
    return v;
  endfunction

  // Drive one cycle on dut0, update the scoreboard, check read data.
  task automatic step0(input logic c, w, r, input logic [7:0] d);
    logic ra, wa;
    @(negedge clk);
    clr = c; wr = w; rd = r; wd = d;
    ra = r && (mq.size() != 0);
    wa = w && ((mq.size() < D) || ra);
    if (c) begin
      mq.delete();
      m_rd = 8'h00;
    end else begin
      if (ra) m_rd = mq.pop_front();
      if (wa) mq.push_back(d);
    end
    @(posedge clk); #1;
    chk("rd_data", 32'(rdata), 32'(m_rd));
  endtask

  task automatic chk_status(input string p, input int n, input logic o, u);
    chk({p, " count"}, 32'(cnt), 32'(n));
    chk({p, " full"}, 32'(full), 32'(n == D));
    chk({p, " empty"}, 32'(empty), 32'(n == 0));
    chk({p, " almost_full"}, 32'(af), 32'(n >= 6));
    chk({p, " almost_empty"}, 32'(ae), 32'(n <= 2));
    chk({p, " overflow"}, 32'(ovf), 32'(o));
    chk({p, " underflow"}, 32'(udf), 32'(u));
  endtask

  initial begin
    // 1: fill 0x11..0x18, then drain
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, 0, 8'(8'h11 + i), i + 1, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 1, 8'h00, 7 - i, 0, 0));
    // 3: read on empty, then read+write on empty
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 8'h55, 1, 0, 1));
    // 2: fill to full, then a rejected write
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 1, 0, 8'(8'h21 + i), i + 2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'hAA, 8, 1, 1));
    // 4: read+write while full, then drain across the pointer wrap
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 1, 8'h99, 8, 1, 1));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 1, 8'h00, 7 - i, 1, 1));
    // flush with write+read pending: both ignored, flags cleared
    tbl.push_back(mk(0, 1, 0, 8'h31, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'h32, 2, 1, 1));
    tbl.push_back(mk(1, 1, 1, 8'hEE, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h41, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0));

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk_status("reset", 0, 0, 0);
    chk("reset rd_data", 32'(rdata), 32'h0);
    chk("reset fwft rd_data", 32'(f_rdata), 32'h0);
    chk("reset fwft empty", 32'(f_empty), 32'h1);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      step0(tbl[i].clr, tbl[i].wr, tbl[i].rd, tbl[i].wd);
      chk_status($sformatf("row%0d", i), tbl[i].cnt, tbl[i].ovf, tbl[i].udf);
    end

    // 6: asynchronous reset mid-stream
    step0(0, 0, 1, 8'h00);
    chk("pre-reset underflow", 32'(udf), 32'h1);
    for (int i = 0; i < 5; i++) step0(0, 1, 0, 8'(8'h61 + i));
    chk("pre-reset count", 32'(cnt), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_status("async reset", 0, 0, 0);
    chk("async reset rd_data", 32'(rdata), 32'h0);
    @(negedge clk);
    wr = 0; rd = 0; clr = 0;
    rst_n = 1'b1;
    mq.delete();
    m_rd = 8'h00;
    step0(0, 1, 0, 8'h77);
    chk("post-reset count", 32'(cnt), 32'd1);
    step0(0, 0, 1, 8'h00);
    chk("post-reset empty", 32'(empty), 32'h1);
    @(negedge clk) rd = 0;

    // 5: first-word-fall-through
    @(negedge clk) begin fwr = 1; fwd = 8'h3C; end
    @(posedge clk); #1;
    chk("fwft first word", 32'(f_rdata), 32'h3C);
    chk("fwft empty after write", 32'(f_empty), 32'h0);
    chk("fwft count", 32'(f_cnt), 32'd1);
    @(negedge clk) fwr = 0;
    @(posedge clk); #1;
    chk("fwft hold", 32'(f_rdata), 32'h3C);
    @(negedge clk) begin fwr = 1; fwd = 8'h4D; end
    @(posedge clk); #1;
    chk("fwft head kept", 32'(f_rdata), 32'h3C);
    chk("fwft count2", 32'(f_cnt), 32'd2);
    @(negedge clk) begin fwr = 0; frd = 1; end
    @(posedge clk); #1;
    chk("fwft pop", 32'(f_rdata), 32'h4D);
    @(posedge clk); #1;
    chk("fwft drained empty", 32'(f_empty), 32'h1);
    chk("fwft drained data", 32'(f_rdata), 32'h0);
    chk("fwft no underflow", 32'(f_udf), 32'h0);
    @(negedge clk) frd = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sync_fifo_watermark.md
Name: sync_fifo_watermark

Overview:
Parametrised synchronous FIFO that succeeds the basic full/empty FIFO. It adds:
- configurable depth;
- selectable standard or first-word-fall-through (FWFT) read mode;
- fill-level count output;
- programmable almost-full and almost-empty watermarks;
- synchronous flush;
- sticky overflow and underflow error flags.

It sits between the UART baud-domain TX/RX engines and the host register interface as the TX and RX data buffer.

Parameters:
- DATA_WIDTH, 8: bits per entry.
- DEPTH, 16: number of entries; power of two, at least 2.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2: almost_full_o asserts when count is at least this value; range 1..DEPTH.
- AE_LEVEL, 2: almost_empty_o asserts when count is at most this value; range 0..DEPTH-1.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_n_i, input, 1: reset, asynchronous and active-low.
- clr_i, input, 1: synchronous flush; empties the FIFO and clears the error flags.
- write_i, input, 1: write request.
- wr_data_i, input, DATA_WIDTH: write data.
- read_i, input, 1: read request.
- rd_data_o, output, DATA_WIDTH: read data.
- full_o, output, 1: count equals DEPTH.
- empty_o, output, 1: count equals 0.
- almost_full_o, output, 1: count is at least AF_LEVEL.
- almost_empty_o, output, 1: count is at most AE_LEVEL.
- count_o, output, $clog2(DEPTH)+1: current number of stored entries.
- overflow_o, output, 1: sticky flag; a write was rejected.
- underflow_o, output, 1: sticky flag; a read was rejected.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - Read pointer, write pointer and count go to 0.
  - empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0.
  - overflow_o=0, underflow_o=0, rd_data_o=0.
  - Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is held in a separate register.
- Write acceptance: wr_acc = write_i && (!full_o || rd_acc).
- Read acceptance: rd_acc = read_i && !empty_o.
- Accepted write: mem[wr_ptr] gets wr_data_i; wr_ptr increments.
- Accepted read: rd_ptr increments.
- Count update: count_o increments on wr_acc only, decrements on rd_acc only, and is unchanged when both are accepted.
- Full and simultaneous read+write: both are accepted, count stays DEPTH, full_o stays 1.
- Empty and simultaneous read+write: the write is accepted; the read is rejected and sets underflow_o. A write never bypasses into the same cycle's read.
- Rejected write (write_i && full_o && !rd_acc): the data is dropped and overflow_o is set. It stays set until clr_i or reset.
- Rejected read (read_i && empty_o): pointers are unchanged, underflow_o is set (sticky), and rd_data_o holds its previous value.
- All status outputs (full_o, empty_o, almost_*, count_o) are registered. They update in the same edge as the pointers, so they reflect the post-operation state one cycle after the request.
- FWFT=0:
  - rd_data_o is a register loaded with mem[rd_ptr] on the edge where rd_acc is true.
  - Data is valid the cycle after the read request.
  - rd_data_o holds its value otherwise, including when the FIFO is empty.
- FWFT=1:
  - rd_data_o = mem[rd_ptr] whenever empty_o=0, and 0 when empty_o=1.
  - read_i acknowledges and pops the displayed word.
  - The first written word appears on rd_data_o the cycle after its write edge.
- clr_i (synchronous):
  - Pointers and count go to 0; overflow_o and underflow_o are cleared.
  - Status outputs return to their reset values.
  - rd_data_o goes to 0 in both modes.
  - clr_i has priority over write_i and read_i in the same cycle; both requests are ignored and flag nothing.
- Reset asserted mid-operation: all outputs go to their reset values immediately. The first post-reset write lands at address 0.
- Watermarks are compared against the next-state count and registered together with it, so they never lag count_o.

Test Plan:
1. DEPTH=8, FWFT=0: write 0x11..0x18 on 8 consecutive cycles.
   - Expected: count_o steps 1..8; almost_full_o rises at count 6; full_o=1 after the 8th write.
   - Then 8 reads: rd_data_o shows 0x11..0x18, each one cycle after its read; empty_o=1 after the 8th read.
2. FIFO full (count 8): write_i=1 alone with wr_data_i=0xAA.
   - Expected: overflow_o=1; count stays 8; a later drain never returns 0xAA.
   - Then clr_i=1 for one cycle: count_o=0, empty_o=1, overflow_o=0.
3. FIFO empty: read_i=1.
   - Expected: underflow_o=1; count_o=0; rd_data_o unchanged.
   - Then read_i=1 and write_i=1 with 0x55 in the same cycle: count_o=1, underflow_o still 1.
4. Full FIFO: read_i=1 and write_i=1 with 0x99 for 3 cycles.
   - Expected: count_o stays 8, full_o=1, no overflow.
   - Drain order: old entries 4..8, then 0x99 three times; wrap-around of both pointers is exercised.
5. FWFT=1: write 0x3C.
   - Expected: rd_data_o=0x3C the next cycle with no read issued.
   - read_i=1: empty_o=1 and rd_data_o=0 the next cycle.
6. Write 5 entries, then drop rst_n_i low mid-stream between edges.
   - Expected: count_o=0, empty_o=1, flags 0 immediately.
   - After release, write 0x77 then read: 0x77 is returned.
